// File: rtl/matrix_info_table.sv
// ============================================================================
// Module   : matrix_info_table
// Purpose  : Per-(m,n) matrix occupancy table with store/delete/query/clear.
// Revision : 1.0
// ============================================================================
`default_nettype none

module matrix_info_table #(
  parameter int MAX_PER_DIM = 2,
  parameter bit OVERWRITE   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [1:0]  op,
  input  logic [2:0]  dim_m,
  input  logic [2:0]  dim_n,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status,
  output logic [1:0]  slot,
  output logic [49:0] info_table,
  output logic [5:0]  total_count
);

  localparam logic [1:0] C_OP_STORE  = 2'b00;
  localparam logic [1:0] C_OP_DELETE = 2'b01;
  localparam logic [1:0] C_OP_QUERY  = 2'b10;
  localparam logic [1:0] C_OP_CLEAR  = 2'b11;

  localparam logic [1:0] C_ST_OK    = 2'b00;
  localparam logic [1:0] C_ST_BADIM = 2'b01;
  localparam logic [1:0] C_ST_FULL  = 2'b10;
  localparam logic [1:0] C_ST_EMPTY = 2'b11;

  localparam logic [1:0] C_MAX      = 2'(MAX_PER_DIM);
  localparam logic [1:0] C_PTR_LAST = 2'(MAX_PER_DIM - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [2:0]        m_q, m_d;
  logic [2:0]        n_q, n_d;
  logic [4:0]        idx_q, idx_d;
  logic              bad_q, bad_d;
  logic [24:0][1:0]  cnt_q, cnt_d;
  logic [24:0][1:0]  ptr_q, ptr_d;
  logic [5:0]        total_q, total_d;
  logic [1:0]        status_q, status_d;
  logic [1:0]        slot_q, slot_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [1:0]        cnt_cur;
  logic [1:0]        ptr_cur;
  logic [6:0]        cnt_sum;

  assign cnt_cur = cnt_q[idx_q];
  assign ptr_cur = ptr_q[idx_q];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    m_d      = m_q;
    n_d      = n_q;
    idx_d    = idx_q;
    bad_d    = bad_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    status_d = status_q;
    slot_d   = slot_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = op;
          m_d     = dim_m;
          n_d     = dim_n;
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        bad_d   = (op_q != C_OP_CLEAR) &&
                  ((m_q == 3'd0) || (m_q > 3'd5) || (n_q == 3'd0) || (n_q > 3'd5));
        idx_d   = ({2'b00, m_q} - 5'd1) * 5'd5 + {2'b00, n_q} - 5'd1;
        state_d = ST_UPDATE;
      end

      ST_UPDATE: begin
        state_d  = ST_RESP;
        status_d = C_ST_OK;
        slot_d   = 2'd0;
        if (bad_q) begin
          status_d = C_ST_BADIM;
        end else begin
          case (op_q)
            C_OP_STORE: begin
              if (cnt_cur < C_MAX) begin
                cnt_d[idx_q] = cnt_cur + 2'd1;
                slot_d       = cnt_cur;
              end else if (OVERWRITE) begin
                // Full entry: recycle the oldest slot round-robin.
                slot_d       = ptr_cur;
                ptr_d[idx_q] = (ptr_cur == C_PTR_LAST) ? 2'd0 : ptr_cur + 2'd1;
              end else begin
                status_d = C_ST_FULL;
              end
            end
            C_OP_DELETE: begin
              if (cnt_cur != 2'd0) begin
                cnt_d[idx_q] = cnt_cur - 2'd1;
                slot_d       = cnt_cur - 2'd1;
                if (cnt_cur == 2'd1) begin
                  ptr_d[idx_q] = 2'd0;
                end
              end else begin
                status_d = C_ST_EMPTY;
              end
            end
            C_OP_QUERY: begin
              slot_d   = cnt_cur;
              status_d = (cnt_cur == 2'd0) ? C_ST_EMPTY : C_ST_OK;
            end
            default: begin
              cnt_d = '0;
              ptr_d = '0;
            end
          endcase
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_RESP);
  end

  // Total can reach 75 with three slots per entry; clamp to the 6-bit port.
  always_comb begin
    cnt_sum = 7'd0;
    for (int i = 0; i < 25; i++) begin
      cnt_sum = cnt_sum + {5'd0, cnt_d[i]};
    end
    total_d = (cnt_sum > 7'd63) ? 6'd63 : cnt_sum[5:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= 2'd0;
      m_q      <= 3'd0;
      n_q      <= 3'd0;
      idx_q    <= 5'd0;
      bad_q    <= 1'b0;
      cnt_q    <= '0;
      ptr_q    <= '0;
      total_q  <= 6'd0;
      status_q <= 2'd0;
      slot_q   <= 2'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      m_q      <= m_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      bad_q    <= bad_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      total_q  <= total_d;
      status_q <= status_d;
      slot_q   <= slot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign status      = status_q;
  assign slot        = slot_q;
  assign info_table  = cnt_q;
  assign total_count = total_q;

endmodule

`default_nettype wire
